// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
// Purpose : bundles the timing outputs of vga_timing so that each drawing
//           stage can take the whole set through one port.
// Signals : hcount_out  [10:0] pixel index within line
//           hsync_out          horizontal sync, active-high
//           hblnk_out          horizontal blanking
//           vcount_out  [10:0] line index within frame
//           vsync_out          vertical sync, active-high
//           vblnk_out          vertical blanking
//           frame_start        one-cycle strobe at (0,0) after a frame wrap
//           frame_cnt   [15:0] completed-frame counter
// Modports: master = timing generator (drives), slave = consumer (reads).
// -----------------------------------------------------------------------------
interface vga_timing_if;
   logic [10:0] hcount_out;
   logic        hsync_out;
   logic        hblnk_out;
   logic [10:0] vcount_out;
   logic        vsync_out;
   logic        vblnk_out;
   logic        frame_start;
   logic [15:0] frame_cnt;

   modport master (
      output hcount_out, hsync_out, hblnk_out,
      output vcount_out, vsync_out, vblnk_out,
      output frame_start, frame_cnt
   );

   modport slave (
      input hcount_out, hsync_out, hblnk_out,
      input vcount_out, vsync_out, vblnk_out,
      input frame_start, frame_cnt
   );
endinterface

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Purpose : free-running VGA timing generator (1024x768 @ 60 Hz with the
//           default parameters, 65 MHz pixel clock). Produces the pixel/line
//           counters plus active-high sync and blanking flags for the video
//           pipeline.
// Ports   : pclk   in   pixel clock
//           rst    in   synchronous active-high reset
//           vga_o  out  vga_timing_if.master (counts, sync, blank, frame info)
// Config  : `define VGA_TIMING_FRAME_CNT_EN to build the frame_start strobe
//           and the 16-bit frame_cnt counter. Without it both are tied to 0
//           and no registers are built for them; the ports remain.
// -----------------------------------------------------------------------------
module vga_timing #(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned H_FP     = 24,
   parameter int unsigned H_SYNC   = 136,
   parameter int unsigned H_BP     = 160,
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned V_FP     = 3,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 29
) (
   input  logic         pclk,
   input  logic         rst,
   vga_timing_if.master vga_o
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_BLNK_START = 11'(H_ACTIVE);
   localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
   localparam logic [10:0] V_BLNK_START = 11'(V_ACTIVE);
   localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] hcount_q, hcount_d;
   logic [10:0] vcount_q, vcount_d;
   logic        hsync_q,  hsync_d;
   logic        hblnk_q,  hblnk_d;
   logic        vsync_q,  vsync_d;
   logic        vblnk_q,  vblnk_d;
   logic        h_wrap;

   // Next counts first; the flags are decoded from those next counts so that
   // the registered counts and flags always describe the same pixel.
   always_comb begin
      h_wrap   = (hcount_q == H_LAST);
      hcount_d = hcount_q + 11'd1;
      vcount_d = vcount_q;
      if (h_wrap) begin
         hcount_d = '0;
         if (vcount_q == V_LAST) begin
            vcount_d = '0;
         end else begin
            vcount_d = vcount_q + 11'd1;
         end
      end

      hblnk_d = (hcount_d >= H_BLNK_START);
      hsync_d = (hcount_d >= H_SYNC_START) && (hcount_d < H_SYNC_END);
      vblnk_d = (vcount_d >= V_BLNK_START);
      vsync_d = (vcount_d >= V_SYNC_START) && (vcount_d < V_SYNC_END);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         hcount_q <= '0;
         vcount_q <= '0;
         hsync_q  <= 1'b0;
         hblnk_q  <= 1'b0;
         vsync_q  <= 1'b0;
         vblnk_q  <= 1'b0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         hsync_q  <= hsync_d;
         hblnk_q  <= hblnk_d;
         vsync_q  <= vsync_d;
         vblnk_q  <= vblnk_d;
      end
   end

   assign vga_o.hcount_out = hcount_q;
   assign vga_o.vcount_out = vcount_q;
   assign vga_o.hsync_out  = hsync_q;
   assign vga_o.hblnk_out  = hblnk_q;
   assign vga_o.vsync_out  = vsync_q;
   assign vga_o.vblnk_out  = vblnk_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic        frame_wrap;
   logic        frame_start_q, frame_start_d;
   logic [15:0] frame_cnt_q,   frame_cnt_d;

   // The last pixel of the last line: the next edge lands on (0,0). Because
   // the strobe is registered from this, the (0,0) seen during reset never
   // produces a pulse.
   always_comb begin
      frame_wrap    = h_wrap && (vcount_q == V_LAST);
      frame_start_d = frame_wrap;
      frame_cnt_d   = frame_cnt_q;
      if (frame_wrap) begin
         frame_cnt_d = frame_cnt_q + 16'd1;   // rolls over 16'hFFFF -> 0
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign vga_o.frame_start = frame_start_q;
   assign vga_o.frame_cnt   = frame_cnt_q;
`else
   assign vga_o.frame_start = 1'b0;
   assign vga_o.frame_cnt   = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
// Two instances: one with the full 1024x768 parameters (horizontal timing and
// reset behaviour) and one with a shrunken geometry so that whole frames,
// frame wraps and frame_start spacing fit in a short run. Both are compared
// every cycle against a position-based arithmetic model, with random resets.
// -----------------------------------------------------------------------------
module tb_vga_timing;

   // shrunken geometry: H_TOTAL=32, V_TOTAL=20, frame = 640 cycles
   localparam int S_HA = 20, S_HF = 3, S_HS = 5, S_HB = 4;
   localparam int S_VA = 12, S_VF = 2, S_VS = 3, S_VB = 3;
   localparam int S_FT = 640;

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic rst_s = 1'b1;
   logic rst_d = 1'b1;

   vga_timing_if if_s ();
   vga_timing_if if_d ();

   vga_timing #(
      .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
   ) dut_s (
      .pclk  (pclk),
      .rst   (rst_s),
      .vga_o (if_s)
   );

   vga_timing dut_d (
      .pclk  (pclk),
      .rst   (rst_d),
      .vga_o (if_d)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      longint h, v, hs, hb, vs, vb, fs, fc;
   } exp_t;

   // Expected outputs purely from the number of clocks since reset released.
   function automatic exp_t model(longint p, int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, int vb);
      exp_t   e;
      longint ht, vt, ft;
      ht   = ha + hf + hs + hb;
      vt   = va + vf + vs + vb;
      ft   = ht * vt;
      e.h  = p % ht;
      e.v  = (p / ht) % vt;
      e.hb = (e.h >= ha) ? 1 : 0;
      e.hs = (e.h >= ha + hf && e.h < ha + hf + hs) ? 1 : 0;
      e.vb = (e.v >= va) ? 1 : 0;
      e.vs = (e.v >= va + vf && e.v < va + vf + vs) ? 1 : 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
      e.fs = (p != 0 && p % ft == 0) ? 1 : 0;
      e.fc = (p / ft) % 65536;
`else
      e.fs = 0;
      e.fc = 0;
`endif
      return e;
   endfunction

   task automatic chk(string name, longint act, longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic cmp_all(string tag, exp_t e, longint h, longint v, longint hs,
                          longint hb, longint vs, longint vb, longint fs, longint fc);
      chk({tag, ".hcount"}, h, e.h);
      chk({tag, ".vcount"}, v, e.v);
      chk({tag, ".hsync"}, hs, e.hs);
      chk({tag, ".hblnk"}, hb, e.hb);
      chk({tag, ".vsync"}, vs, e.vs);
      chk({tag, ".vblnk"}, vb, e.vb);
      chk({tag, ".frame_start"}, fs, e.fs);
      chk({tag, ".frame_cnt"}, fc, e.fc);
   endtask

   // position trackers (clocks since the last reset edge)
   longint p_s = 0, p_d = 0;
   bit started_s = 0, started_d = 0;

   always @(posedge pclk) begin
      started_s <= 1'b1;
      started_d <= 1'b1;
      p_s <= rst_s ? 64'sd0 : p_s + 1;
      p_d <= rst_d ? 64'sd0 : p_d + 1;
   end

   always @(negedge pclk) begin
      if (started_s)
         cmp_all("s", model(p_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB),
                 if_s.hcount_out, if_s.vcount_out, if_s.hsync_out, if_s.hblnk_out,
                 if_s.vsync_out, if_s.vblnk_out, if_s.frame_start, if_s.frame_cnt);
      if (started_d)
         cmp_all("d", model(p_d, 1024, 24, 136, 160, 768, 3, 6, 29),
                 if_d.hcount_out, if_d.vcount_out, if_d.hsync_out, if_d.hblnk_out,
                 if_d.vsync_out, if_d.vblnk_out, if_d.frame_start, if_d.frame_cnt);
   end

   task automatic lit_zero(string tag, longint h, longint v, longint hs, longint hb,
                           longint vs, longint vb, longint fs, longint fc);
      exp_t z;
      z = '{0, 0, 0, 0, 0, 0, 0, 0};
      cmp_all({tag, ".rst"}, z, h, v, hs, hb, vs, vb, fs, fc);
   endtask

   initial begin
      int     hb_rise_h, hs_cnt, hs_min, hs_max, wrap_seen;
      int     vs_cnt, vb_cnt, fs_cnt, fs_high_run, fs_run_max, fc_at_2nd;
      longint fs_t1, fs_t2, z_t1, z_t2, prev_h, prev_v, prev_hb;
      int     z_cnt, fs_seen;
      bit     found;

      hb_rise_h = -1; hs_cnt = 0; hs_min = 9999; hs_max = -1; wrap_seen = 0;
      vs_cnt = 0; vb_cnt = 0; fs_cnt = 0; fs_high_run = 0; fs_run_max = 0;
      fc_at_2nd = -1; fs_t1 = 0; fs_t2 = 0; z_t1 = 0; z_t2 = 0; z_cnt = 0;
      fs_seen = 0;

      // reset held for 5 cycles: every output is 0
      repeat (5) begin
         @(negedge pclk);
         lit_zero("d", if_d.hcount_out, if_d.vcount_out, if_d.hsync_out, if_d.hblnk_out,
                  if_d.vsync_out, if_d.vblnk_out, if_d.frame_start, if_d.frame_cnt);
      end
      rst_s = 1'b0;
      rst_d = 1'b0;

      @(negedge pclk);
      chk("d.first_hcount", if_d.hcount_out, 1);
      chk("d.first_vcount", if_d.vcount_out, 0);
      chk("s.first_hcount", if_s.hcount_out, 1);
      prev_h  = if_d.hcount_out;
      prev_v  = if_d.vcount_out;
      prev_hb = if_d.hblnk_out;

      // 1400 cycles: one full line of the real geometry, two frames of the small one
      for (int c = 2; c <= 1400; c++) begin
         @(negedge pclk);
         // full geometry, horizontal timing
         if (!prev_hb && if_d.hblnk_out && hb_rise_h < 0) hb_rise_h = int'(if_d.hcount_out);
         if (if_d.hsync_out && if_d.vcount_out == 0) begin
            hs_cnt++;
            if (int'(if_d.hcount_out) < hs_min) hs_min = int'(if_d.hcount_out);
            if (int'(if_d.hcount_out) > hs_max) hs_max = int'(if_d.hcount_out);
         end
         if (prev_h == 1343) begin
            wrap_seen++;
            chk("d.hwrap_hcount", if_d.hcount_out, 0);
            chk("d.hwrap_vcount", if_d.vcount_out, prev_v + 1);
         end
         prev_h  = if_d.hcount_out;
         prev_v  = if_d.vcount_out;
         prev_hb = if_d.hblnk_out;

         // small geometry, frame-level behaviour
         if (c < S_FT && if_s.vsync_out) vs_cnt++;
         if (c < S_FT && if_s.vblnk_out) vb_cnt++;
         if (if_s.hcount_out == 0 && if_s.vcount_out == 0) begin
            z_cnt++;
            if (z_cnt == 1) z_t1 = c;
            if (z_cnt == 2) z_t2 = c;
         end
         if (if_s.frame_start) begin
            fs_high_run++;
            if (fs_high_run > fs_run_max) fs_run_max = fs_high_run;
            if (fs_high_run == 1) begin
               fs_cnt++;
               if (fs_cnt == 1) fs_t1 = c;
               if (fs_cnt == 2) begin
                  fs_t2 = c;
                  fc_at_2nd = int'(if_s.frame_cnt);
               end
            end
         end else begin
            fs_high_run = 0;
         end
      end

      chk("d.hblnk_rise_at", hb_rise_h, 1024);
      chk("d.hsync_width", hs_cnt, 136);
      chk("d.hsync_first", hs_min, 1048);
      chk("d.hsync_last", hs_max, 1183);
      chk("d.hwrap_seen", wrap_seen, 1);
      chk("s.frame_period", z_t2 - z_t1, S_FT);
      chk("s.vsync_cycles", vs_cnt, 3 * 32);
      chk("s.vblnk_cycles", vb_cnt, 8 * 32);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("s.frame_start_pulses", fs_cnt, 2);
      chk("s.frame_start_gap", fs_t2 - fs_t1, S_FT);
      chk("s.frame_start_width", fs_run_max, 1);
      chk("s.frame_cnt_after_2nd", fc_at_2nd, 2);
`else
      chk("s.frame_start_pulses", fs_cnt, 0);
      chk("s.frame_cnt_held", if_s.frame_cnt, 0);
`endif

      // mid-frame reset on the small instance at (10,7)
      found = 0;
      for (int c = 0; c < 700 && !found; c++) begin
         @(negedge pclk);
         if (if_s.hcount_out == 10 && if_s.vcount_out == 7) found = 1;
      end
      chk("s.reach_10_7", found, 1);
      rst_s = 1'b1;
      @(negedge pclk);
      lit_zero("s.mid", if_s.hcount_out, if_s.vcount_out, if_s.hsync_out, if_s.hblnk_out,
               if_s.vsync_out, if_s.vblnk_out, if_s.frame_start, if_s.frame_cnt);
      rst_s = 1'b0;
      @(negedge pclk);
      chk("s.restart_hcount", if_s.hcount_out, 1);
      chk("s.restart_vcount", if_s.vcount_out, 0);

      // random reset pulses on either instance; the per-cycle model tracks them
      for (int i = 0; i < 15; i++) begin
         int gap, len, which;
         gap   = int'($urandom_range(50, 1500));
         len   = int'($urandom_range(1, 3));
         which = int'($urandom_range(0, 1));
         repeat (gap) @(negedge pclk);
         $display("reset pulse %0d: dut=%s len=%0d after %0d cycles", i,
                  (which != 0) ? "s" : "d", len, gap);
         if (which != 0) rst_s = 1'b1; else rst_d = 1'b1;
         repeat (len) @(negedge pclk);
         rst_s = 1'b0;
         rst_d = 1'b0;
      end
      repeat (1500) @(negedge pclk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
